nes_joypad_responder: RTL and testbench
=======================================

# nes_joypad_responder

Device-side end of the NES controller serial interface: emulates the controller's 8-bit parallel-in/serial-out shift register so an external NES-style host (or the on-chip joypad reader, for loopback) can poll the FPGA's merged button state over strobe/clock/data pins. It sits between the button sources (onboard BTNs ORed with the USB HID decoder's `o_btn`) and the gp/gn header pins. Its asynchronous pin inputs are synchronized and glitch-filtered, and it reports poll completion back to the core.

## Interface
- `C_sync_stages`, default 2: synchronizer flops per pin input; minimum 2.
- `C_filter_len`, default 4: number of consecutive equal synchronized samples required to accept a pin level change; minimum 1.
- `C_post_data`, default 1: logical bit shifted in after the 8 buttons. 1 means "pressed", which matches an official pad's low data line.

- `clock`, in, 1: system clock, 21.477 MHz core clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `i_buttons`, in, 8: {right,left,down,up,start,select,b,a}, active-high, synchronous to `clock`.
- `i_strobe`, in, 1: host latch pin, asynchronous.
- `i_clk`, in, 1: host shift-clock pin, asynchronous, idle high.
- `o_data`, out, 1: serial data pin level, active-low (0 = pressed), registered.
- `o_bit_count`, out, 4: buttons shifted since the last latch, 0..8, saturating.
- `o_read_done`, out, 1: single-cycle pulse when the 8th shift occurs.

## Operation
- **Pin conditioning** (per pin):
  - The pin passes through `C_sync_stages` flops, then the filter.
  - The filter holds a filtered level and a counter. The counter increments while the synchronized sample differs from the filtered level and clears when the sample equals it.
  - When the counter reaches `C_filter_len`, the filtered level takes the sample and the counter clears.
  - A one-cycle rise or fall flag is produced from the filtered level's previous value.
- **Shift register** `shreg[7:0]`, with bit 0 = A:
  - Filtered strobe high: `shreg <= i_buttons` every cycle; `o_bit_count <= 0`; clock edges are ignored.
  - Filtered strobe falling edge: one final load of `i_buttons` and `o_bit_count <= 0`. This takes priority over a simultaneous clock rise, which is then not shifted.
  - Filtered clock rising edge while strobe is low: `shreg <= {C_post_data, shreg[7:1]}`. `o_bit_count` increments, saturating at 8.
  - On the 7→8 transition only, `o_read_done` pulses.
  - Further rising edges keep shifting `C_post_data` in; the count stays at 8 and there is no further pulse.
- **Output:** `o_data <= ~shreg[0]`, registered.
- **Buttons:** `i_buttons` is sampled only on load cycles. Changes while shifting do not affect the current poll.

## Timing
- **Reset values:**
  - Sync flops and filtered levels: strobe 0, clk 1.
  - Filter counters: 0.
  - `shreg`: 0.
  - `o_data`: 1 (released).
  - `o_bit_count`: 0.
  - `o_read_done`: 0.
- **Reset mid-poll:** asserting `reset` mid-poll aborts the poll immediately to the reset values. The first poll after release requires a fresh strobe.
- **Pin-to-output latency:** a stable pin change reaches `o_data` in `C_sync_stages + C_filter_len + 2` clocks (8 with defaults, about 372 ns).
- **Glitch rejection:** pulses shorter than `C_filter_len` clocks after synchronization are rejected entirely.
- **Host timing:** hosts must hold strobe and clock phases ≥ `C_sync_stages + C_filter_len` clocks. The NES timing of roughly 0.5 µs low pulses meets this with defaults.
- **Read-done alignment:** `o_read_done` is asserted in the same cycle that `o_bit_count` becomes 8.
- **Clocking:** there is no combinational path from any input to any output.

## Structure
- **Package `nes_joypad_pkg`:**
  - Button bit-index constants (`BTN_A`=0 … `BTN_RIGHT`=7).
  - Idle pin levels (`STROBE_IDLE`=0, `CLK_IDLE`=1).
  - Pad width constant 8.
- **Sub-module `pin_filter`:** synchronizer, glitch filter and edge flags. It is parameterized by `C_sync_stages`, `C_filter_len` and the reset level, and is instantiated once each for strobe and clk.
- **Top level:** the top holds the load/shift logic, the counter and the output register.

## Test plan
- **Basic poll:** `i_buttons`=8'b1000_0001, strobe pulse of 20 clocks, then 8 clock low pulses of 20 clocks → `o_data` sequence 0,1,1,1,1,1,1,0; `o_read_done` pulses once with count 8.
- **Post-data:** a 9th and 10th clock pulse → `o_data`=0 (with `C_post_data`=1), count stays 8, no pulse.
- **Glitch rejection:** a 3-clock clk glitch with `C_filter_len`=4 → no shift, count unchanged; a 4-clock pulse shifts once.
- **Strobe held high:** strobe held high with 5 clock pulses and `i_buttons` toggling bit 0 → `o_data` tracks ~A within 8 clocks, count stays 0.
- **Simultaneous edges:** strobe fall and clk rise in the same synchronized cycle → load wins, `o_data` = ~A, count 0.
- **Reset mid-poll:** assert `reset` after 3 shifts → `o_data`=1 and count 0 immediately; after release, a new strobe+8 clocks reproduces the full button pattern.

Source files
------------

// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad responder: button indices, idle pin levels, pad width.
package nes_joypad_pkg;

    localparam int unsigned PAD_WIDTH = 8;

    // Bit positions inside the button vector / shift register (bit 0 shifts out first).
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // Levels the host pins rest at between polls; also the filters' reset levels.
    localparam logic STROBE_IDLE = 1'b0;
    localparam logic CLK_IDLE    = 1'b1;

    localparam logic [3:0] BIT_COUNT_MAX = 4'(PAD_WIDTH);

    // Saturating increment of the shifted-bit counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] count);
        return (count == BIT_COUNT_MAX) ? count : count + 4'd1;
    endfunction

endpackage

// File: rtl/nes_joypad_responder_pin_filter.sv
// Pin conditioner: synchronizer chain, consecutive-sample glitch filter and edge flags.
module pin_filter #(
    parameter int unsigned C_sync_stages = 2,
    parameter int unsigned C_filter_len  = 4,
    parameter logic        C_reset_level = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(C_filter_len + 1);

    logic [C_sync_stages-1:0] sync_q;
    logic                     sample;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     level_q, level_d;
    logic                     prev_q;

    assign sample = sync_q[C_sync_stages-1];

    // Synchronizer chain; the pin enters at bit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {C_sync_stages{C_reset_level}};
        end else begin
            sync_q <= {sync_q[C_sync_stages-2:0], pin};
        end
    end

    // Accept a new level only after C_filter_len consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CW'(C_filter_len - 1)) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state and previous filtered level for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= C_reset_level;
            prev_q  <= C_reset_level;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~prev_q;
    assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/nes_joypad_responder.sv
// Device side of the NES pad protocol: latches buttons on strobe, shifts them out on host clock.
module nes_joypad_responder
    import nes_joypad_pkg::*;
#(
    parameter int unsigned C_sync_stages = 2,
    parameter int unsigned C_filter_len  = 4,
    parameter logic        C_post_data   = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PAD_WIDTH-1:0] i_buttons,
    input  logic                 i_strobe,
    input  logic                 i_clk,
    output logic                 o_data,
    output logic [3:0]           o_bit_count,
    output logic                 o_read_done
);

    logic strobe_level, strobe_rise, strobe_fall;
    logic clk_level, clk_rise, clk_fall;
    logic unused_edges;

    logic [PAD_WIDTH-1:0] shreg_q, shreg_d;
    logic [3:0]           count_q, count_d;
    logic                 done_q, done_d;
    logic                 data_q;

    pin_filter #(
        .C_sync_stages (C_sync_stages),
        .C_filter_len  (C_filter_len),
        .C_reset_level (STROBE_IDLE)
    ) u_strobe_filter (
        .clock (clock),
        .reset (reset),
        .pin   (i_strobe),
        .level (strobe_level),
        .rise  (strobe_rise),
        .fall  (strobe_fall)
    );

    pin_filter #(
        .C_sync_stages (C_sync_stages),
        .C_filter_len  (C_filter_len),
        .C_reset_level (CLK_IDLE)
    ) u_clk_filter (
        .clock (clock),
        .reset (reset),
        .pin   (i_clk),
        .level (clk_level),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    assign unused_edges = ^{strobe_rise, clk_level, clk_fall};

    // Load while strobe is high and once more on its fall (beating a coincident clk rise);
    // otherwise shift on each filtered clk rise.
    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (strobe_level || strobe_fall) begin
            shreg_d = i_buttons;
            count_d = '0;
        end else if (clk_rise) begin
            shreg_d = {C_post_data, shreg_q[PAD_WIDTH-1:1]};
            count_d = sat_inc(count_q);
            done_d  = (count_q == BIT_COUNT_MAX - 4'd1);
        end
    end

    // Shift register, counter, done pulse and registered active-low data pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            data_q  <= 1'b1;
        end else begin
            shreg_q <= shreg_d;
            count_q <= count_d;
            done_q  <= done_d;
            data_q  <= ~shreg_q[BTN_A];
        end
    end

    assign o_data      = data_q;
    assign o_bit_count = count_q;
    assign o_read_done = done_q;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Scoreboard bench: stimulus pushes expected pin-level results; monitors compare after pin latency.
module tb_nes_joypad_responder;

    localparam int   SYNC = 2;
    localparam int   FILT = 4;
    localparam int   LAT  = SYNC + FILT + 2;
    localparam logic POST = 1'b1;

    typedef struct {
        logic       data;
        logic [3:0] cnt;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_buttons = 8'h00;
    logic       i_strobe = 1'b0;
    logic       i_clk = 1'b1;
    logic       o_data;
    logic [3:0] o_bit_count;
    logic       o_read_done;

    nes_joypad_responder #(
        .C_sync_stages (SYNC),
        .C_filter_len  (FILT),
        .C_post_data   (POST)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_buttons   (i_buttons),
        .i_strobe    (i_strobe),
        .i_clk       (i_clk),
        .o_data      (o_data),
        .o_bit_count (o_bit_count),
        .o_read_done (o_read_done)
    );

    always #5 clock = ~clock;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: bits latched by the last load and number of shifts since.
    logic [7:0] latched = 8'h00;
    int         shifts = 0;
    int         done_pending = 0;
    int         done_expected = 0;
    int         done_seen = 0;

    exp_t sb_q[$];
    int   due_q[$];
    int   cyc = 0;
    logic prev_strobe = 1'b0;
    logic prev_clk = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic exp_data();
        return (shifts < 8) ? ~latched[shifts] : ~POST;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.data = exp_data();
        e.cnt  = 4'((shifts > 8) ? 8 : shifts);
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic strobe_pulse(input int hi);
        i_strobe = 1'b1;
        wait_cyc(hi);
        i_strobe = 1'b0;
        latched  = i_buttons;
        shifts   = 0;
        push_exp();
        wait_cyc(20);
    endtask

    task automatic clk_pulse(input int lo, input int hi);
        i_clk = 1'b0;
        wait_cyc(lo);
        i_clk = 1'b1;
        if (i_strobe) begin
            latched = i_buttons;
            shifts  = 0;
        end else if (lo >= FILT) begin
            if (shifts == 7) begin
                done_pending++;
                done_expected++;
            end
            if (shifts < 9) shifts++;
        end
        push_exp();
        wait_cyc(hi);
    endtask

    task automatic poll(input logic [7:0] btn, input int nclk);
        i_buttons = btn;
        strobe_pulse(20);
        for (int k = 0; k < nclk; k++) begin
            i_buttons = 8'($urandom);
            clk_pulse(20, 20);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((due_q.size() > 0 || sb_q.size() > 0) && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("drain_due", due_q.size(), 0);
        chk("drain_sb", sb_q.size(), 0);
        due_q.delete();
        sb_q.delete();
        #1;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Pin-event monitor: a strobe fall or clk rise yields an output check LAT clocks later.
    always @(negedge clock) begin
        if (prev_strobe && !i_strobe) due_q.push_back(cyc + LAT);
        if (!prev_clk && i_clk) due_q.push_back(cyc + LAT);
        prev_strobe = i_strobe;
        prev_clk    = i_clk;
        while (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_bit_count", o_bit_count, e.cnt);
            end
        end
    end

    // Done-pulse monitor: every pulse must be expected and coincide with count 8.
    always @(negedge clock) begin
        if (o_read_done) begin
            done_seen++;
            chk("done_count", o_bit_count, 8);
            chk("done_expected", done_pending > 0, 1);
            if (done_pending > 0) done_pending--;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] btn;
        #12;
        chk("reset_o_data", o_data, 1);
        chk("reset_bit_count", o_bit_count, 0);
        chk("reset_read_done", o_read_done, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(5);

        // Basic poll plus two post-data shifts.
        poll(8'b1000_0001, 10);
        drain();

        // Glitch rejection: 3-clock low glitch ignored, 4-clock pulse shifts once.
        poll(8'($urandom), 2);
        clk_pulse(3, 20);
        clk_pulse(4, 20);
        drain();

        // Strobe held high: clk pulses ignored, data follows A.
        i_strobe = 1'b1;
        wait_cyc(20);
        for (int k = 0; k < 5; k++) begin
            i_buttons = 8'($urandom);
            wait_cyc(10);
            clk_pulse(10, 12);
        end
        i_strobe = 1'b0;
        latched  = i_buttons;
        shifts   = 0;
        push_exp();
        wait_cyc(20);
        drain();

        // Simultaneous strobe fall and clk rise: load wins, then a full read.
        i_buttons = 8'($urandom);
        i_strobe  = 1'b1;
        wait_cyc(20);
        i_clk = 1'b0;
        wait_cyc(20);
        i_strobe = 1'b0;
        i_clk    = 1'b1;
        latched  = i_buttons;
        shifts   = 0;
        push_exp();
        push_exp();
        wait_cyc(20);
        for (int k = 0; k < 8; k++) begin
            i_buttons = 8'($urandom);
            clk_pulse(20, 20);
        end
        drain();

        // Reset mid-poll after 3 shifts, then a fresh full poll of the same pattern.
        btn = 8'($urandom);
        poll(btn, 3);
        drain();
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_o_data", o_data, 1);
        chk("midreset_bit_count", o_bit_count, 0);
        chk("midreset_read_done", o_read_done, 0);
        latched = 8'h00;
        shifts  = 0;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        poll(btn, 8);
        drain();

        // Random polls with 8..10 clocks each.
        for (int p = 0; p < 4; p++) begin
            poll(8'($urandom), 8 + int'($urandom_range(0, 2)));
            drain();
        end

        wait_cyc(5);
        chk("done_total", done_seen, done_expected);
        chk("done_outstanding", done_pending, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
